// File: rtl/traffic_pkg.sv
// Shared types for the traffic sensor: light encoding, request FSM states and
// the one-hot LIGHT_RANK codes.
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } lightstate_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PULSE      = 2'd1,
    WAIT_GREEN = 2'd2,
    WAIT_RED   = 2'd3
  } req_state_t;

  localparam logic [4:0] RANK_0 = 5'b00001;
  localparam logic [4:0] RANK_1 = 5'b00010;
  localparam logic [4:0] RANK_2 = 5'b00100;
  localparam logic [4:0] RANK_3 = 5'b01000;
  localparam logic [4:0] RANK_4 = 5'b10000;

endpackage

// File: rtl/traffic_sensor_if.sv
// Sensor-side bundle between the loop detectors / light controller and the
// traffic sensor. The slave modport is the sensor's view.
interface traffic_sensor_if #(
  parameter int CNT_W = 8
);
  logic             MAIN_DET;
  logic             COUNTRY_DET;
  logic [1:0]       COUNTRYLIGHT;
  logic [1:0]       MAINLIGHT;
  logic             COUNTRY_PULSE;
  logic [CNT_W-1:0] COUNTRY_TRAFFIC;
  logic [CNT_W-1:0] MAIN_TRAFFIC;
  logic [4:0]       LIGHT_RANK;
  logic             SENSOR_FAULT;

  modport master (
    output MAIN_DET, COUNTRY_DET, COUNTRYLIGHT, MAINLIGHT,
    input  COUNTRY_PULSE, COUNTRY_TRAFFIC, MAIN_TRAFFIC, LIGHT_RANK, SENSOR_FAULT
  );

  modport slave (
    input  MAIN_DET, COUNTRY_DET, COUNTRYLIGHT, MAINLIGHT,
    output COUNTRY_PULSE, COUNTRY_TRAFFIC, MAIN_TRAFFIC, LIGHT_RANK, SENSOR_FAULT
  );
endinterface

// File: rtl/det_debounce.sv
// Loop-detector front end: 2-flop synchronizer, DEB_CYC-sample debounce and a
// one-cycle strobe that fires on the edge where the debounced level rises.
module det_debounce #(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYC - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          flip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // flip is the DEB_CYC-th consecutive differing sample
  assign differ = (sync_p1 != level);
  assign flip   = differ && (cnt == LAST);
  assign rise   = flip && sync_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (flip) begin
      level <= sync_p1;
      cnt   <= '0;
    end else if (differ) begin
      cnt   <= cnt + CW'(1);
    end else begin
      cnt   <= '0;
    end
  end
endmodule

// File: rtl/traffic_sensor.sv
// Vehicle-detection front end for the traffic-light controller. Optional stuck
// detector is enabled with `define TRAFFIC_SENSOR_STUCK_DETECT_EN.
module traffic_sensor
  import traffic_pkg::*;
#(
  parameter int DEB_CYC    = 4,
  parameter int PULSE_LEN  = 8,
  parameter int WINDOW_CYC = 1000,
  parameter int CNT_W      = 8,
  parameter int RANK_T1    = 4,
  parameter int RANK_T2    = 8,
  parameter int RANK_T3    = 16,
  parameter int RANK_T4    = 32,
  parameter int STUCK_CYC  = 5000
) (
  input  logic          CLK,
  input  logic          RST,
  traffic_sensor_if.slave bus
);
  localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam int WW = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != CNT_MAX)) return v + CNT_W'(1);
    return v;
  endfunction

  function automatic logic [4:0] rank_of(input logic [CNT_W-1:0] v);
    logic [31:0] w;
    w = 32'(v);
    if (w < $unsigned(RANK_T1)) return RANK_0;
    if (w < $unsigned(RANK_T2)) return RANK_1;
    if (w < $unsigned(RANK_T3)) return RANK_2;
    if (w < $unsigned(RANK_T4)) return RANK_3;
    return RANK_4;
  endfunction

  lightstate_t clight;
  lightstate_t mlight;
  assign clight = lightstate_t'(bus.COUNTRYLIGHT);
  assign mlight = lightstate_t'(bus.MAINLIGHT);

  logic main_lvl, main_rise, country_lvl, country_rise;

  det_debounce #(.DEB_CYC(DEB_CYC)) u_main_det (
    .clk(CLK), .rst(RST), .raw(bus.MAIN_DET), .level(main_lvl), .rise(main_rise)
  );

  det_debounce #(.DEB_CYC(DEB_CYC)) u_country_det (
    .clk(CLK), .rst(RST), .raw(bus.COUNTRY_DET), .level(country_lvl), .rise(country_rise)
  );

  logic main_mask, country_mask, fault;

`ifdef TRAFFIC_SENSOR_STUCK_DETECT_EN
  localparam int SW = $clog2(STUCK_CYC + 1);
  localparam logic [SW-1:0] STUCK_LIM = SW'(STUCK_CYC);

  logic [SW-1:0] main_stuck, country_stuck;
  logic          main_fault, country_fault;

  // A vehicle legitimately sits on the loop while its own light is red, so
  // only time spent high under a non-red light counts toward a stuck loop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      main_stuck    <= '0;
      country_stuck <= '0;
      main_fault    <= 1'b0;
      country_fault <= 1'b0;
    end else begin
      if (!main_lvl || mlight == RED)           main_stuck <= '0;
      else if (main_stuck != STUCK_LIM)         main_stuck <= main_stuck + SW'(1);
      if (!country_lvl || clight == RED)        country_stuck <= '0;
      else if (country_stuck != STUCK_LIM)      country_stuck <= country_stuck + SW'(1);
      if (main_stuck == STUCK_LIM)              main_fault <= 1'b1;
      if (country_stuck == STUCK_LIM)           country_fault <= 1'b1;
    end
  end

  assign main_mask    = main_fault;
  assign country_mask = country_fault;
  assign fault        = main_fault | country_fault;
`else
  logic [33:0] unused_stuck;
  assign unused_stuck = {main_lvl, country_lvl, 32'(STUCK_CYC)};
  lightstate_t unused_mlight;
  assign unused_mlight = mlight;
  assign main_mask    = 1'b0;
  assign country_mask = 1'b0;
  assign fault        = 1'b0;
`endif

  logic main_ev, country_ev;
  assign main_ev    = main_rise && !main_mask;
  assign country_ev = country_rise && !country_mask;

  // Country queue: cleared on green, counts arrivals otherwise
  logic [CNT_W-1:0] country_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                  country_cnt <= '0;
    else if (clight == GREEN) country_cnt <= '0;
    else                      country_cnt <= sat_inc(country_cnt, country_ev);
  end

  // Request FSM
  req_state_t    state, state_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic          pulse, pulse_n;
  logic          want;

  assign want = (country_cnt != '0) || country_mask;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      pcnt  <= '0;
      pulse <= 1'b0;
    end else begin
      state <= state_n;
      pcnt  <= pcnt_n;
      pulse <= pulse_n;
    end
  end

  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    pulse_n = pulse;
    case (state)
      IDLE: begin
        if (want && clight == RED) begin
          state_n = PULSE;
          pcnt_n  = '0;
          pulse_n = 1'b1;
        end
      end
      PULSE: begin
        // Green arriving mid-pulse is ignored here; WAIT_GREEN sees it next
        if (pcnt == PW'(PULSE_LEN - 1)) begin
          state_n = WAIT_GREEN;
          pcnt_n  = '0;
          pulse_n = 1'b0;
        end else begin
          pcnt_n  = pcnt + PW'(1);
          pulse_n = 1'b1;
        end
      end
      WAIT_GREEN: if (clight == GREEN) state_n = WAIT_RED;
      WAIT_RED:   if (clight == RED)   state_n = IDLE;
      default: begin
        state_n = IDLE;
        pulse_n = 1'b0;
      end
    endcase
  end

  // Main measurement window
  logic [WW-1:0]    wcnt;
  logic [CNT_W-1:0] run_cnt, run_next, captured, main_traffic;
  logic [4:0]       light_rank;
  logic             win_end;

  assign win_end  = (wcnt == WW'(WINDOW_CYC - 1));
  assign run_next = sat_inc(run_cnt, main_ev);
  assign captured = main_mask ? CNT_W'(RANK_T2 - 1) : run_next;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wcnt         <= '0;
      run_cnt      <= '0;
      main_traffic <= '0;
      light_rank   <= RANK_0;
    end else if (win_end) begin
      wcnt         <= '0;
      run_cnt      <= '0;
      main_traffic <= captured;
      light_rank   <= rank_of(captured);
    end else begin
      wcnt         <= wcnt + WW'(1);
      run_cnt      <= run_next;
    end
  end

  assign bus.COUNTRY_PULSE   = pulse;
  assign bus.COUNTRY_TRAFFIC = country_cnt;
  assign bus.MAIN_TRAFFIC    = main_traffic;
  assign bus.LIGHT_RANK      = light_rank;
  assign bus.SENSOR_FAULT    = fault;
endmodule

// File: tb/tb_traffic_sensor.sv
// Directed bench for traffic_sensor: debounce, request loop, reset, window ranking
// and (with TRAFFIC_SENSOR_STUCK_DETECT_EN) the stuck detector.
module tb_traffic_sensor;
  import traffic_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  traffic_sensor_if #(.CNT_W(8)) bus ();

  traffic_sensor #(
    .DEB_CYC(4), .PULSE_LEN(8), .WINDOW_CYC(1000), .CNT_W(8),
    .RANK_T1(4), .RANK_T2(8), .RANK_T3(16), .RANK_T4(32), .STUCK_CYC(50)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int since = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  // Pulse monitor: counts rises, request falls (not caused by reset) and lengths
  int   n_rise = 0, n_fall = 0, cur_len = 0, last_len = 0;
  logic p_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.COUNTRY_PULSE === 1'b1 && p_prev !== 1'b1) begin
      n_rise  = n_rise + 1;
      cur_len = 1;
    end else if (bus.COUNTRY_PULSE === 1'b1) begin
      cur_len = cur_len + 1;
    end
    if (bus.COUNTRY_PULSE !== 1'b1 && p_prev === 1'b1 && rst === 1'b0) begin
      n_fall   = n_fall + 1;
      last_len = cur_len;
    end
    p_prev = bus.COUNTRY_PULSE;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      since = since + 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      checks   = checks + 1;
      failures = failures + 1;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic wait_rise();
    int k = 0;
    while (bus.COUNTRY_PULSE !== 1'b1 && k < 12) begin
      tick(1);
      k++;
    end
    check("pulse_rise_seen", 32'(bus.COUNTRY_PULSE), 32'd1);
  endtask

  task automatic wait_fall(input int target);
    int k = 0;
    while (n_fall < target && k < 30) begin
      tick(1);
      k++;
    end
    check("pulse_fall_seen", n_fall, target);
  endtask

  task automatic main_vehicle();
    bus.MAIN_DET = 1'b1;
    tick(6);
    bus.MAIN_DET = 1'b0;
    tick(6);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    bus.MAIN_DET     = 1'b0;
    bus.COUNTRY_DET  = 1'b0;
    bus.COUNTRYLIGHT = RED;
    bus.MAINLIGHT    = GREEN;
    tick(3);
    check("rst_pulse", 32'(bus.COUNTRY_PULSE), 0);
    check("rst_country", 32'(bus.COUNTRY_TRAFFIC), 0);
    check("rst_main", 32'(bus.MAIN_TRAFFIC), 0);
    check("rst_rank", 32'(bus.LIGHT_RANK), 32'b00001);
    check("rst_fault", 32'(bus.SENSOR_FAULT), 0);
    tick(1);
    #1 rst = 1'b0;

    // 3-cycle glitch must not produce an arrival
    bus.COUNTRY_DET = 1'b1;
    tick(3);
    bus.COUNTRY_DET = 1'b0;
    tick(10);
    check("glitch_country", 32'(bus.COUNTRY_TRAFFIC), 0);
    check("glitch_no_pulse", n_rise, 0);

    // Held arrival: count appears 6 cycles after the raw edge, pulse one later
    bus.COUNTRY_DET = 1'b1;
    tick(5);
    check("deb_before", 32'(bus.COUNTRY_TRAFFIC), 0);
    tick(1);
    check("deb_after", 32'(bus.COUNTRY_TRAFFIC), 1);
    tick(1);
    check("pulse_start", 32'(bus.COUNTRY_PULSE), 1);
    tick(3);
    bus.COUNTRY_DET = 1'b0;
    wait_fall(1);
    check("pulse_len1", last_len, 8);
    check("pulse_count1", n_rise, 1);
    bus.COUNTRYLIGHT = GREEN;
    tick(1);
    check("green_clear", 32'(bus.COUNTRY_TRAFFIC), 0);
    tick(5);
    bus.COUNTRYLIGHT = YELLOW;
    tick(3);
    bus.COUNTRYLIGHT = RED;
    tick(20);
    check("no_second_pulse", n_rise, 1);

    // Green arriving at pulse cycle 3 does not truncate the pulse
    bus.COUNTRY_DET = 1'b1;
    tick(6);
    bus.COUNTRY_DET = 1'b0;
    wait_rise();
    tick(2);
    bus.COUNTRYLIGHT = GREEN;
    wait_fall(2);
    check("pulse_len2", last_len, 8);
    check("green_hold_clear", 32'(bus.COUNTRY_TRAFFIC), 0);
    tick(10);
    bus.COUNTRYLIGHT = RED;
    tick(20);
    check("one_pulse_per_green", n_rise, 2);

    // Asynchronous reset in the middle of a pulse
    bus.COUNTRY_DET = 1'b1;
    tick(6);
    bus.COUNTRY_DET = 1'b0;
    tick(1);
    check("pulse_before_rst", 32'(bus.COUNTRY_PULSE), 1);
    tick(2);
    #1 rst = 1'b1;
    #1;
    check("rst_async_pulse", 32'(bus.COUNTRY_PULSE), 0);
    check("rst_async_rank", 32'(bus.LIGHT_RANK), 32'b00001);
    check("rst_async_country", 32'(bus.COUNTRY_TRAFFIC), 0);
    tick(2);
    #1 rst = 1'b0;
    since = 0;
    tick(20);
    check("no_req_after_rst", n_fall, 2);
    check("no_pulse_after_rst", 32'(bus.COUNTRY_PULSE), 0);

    // Window 1: 9 vehicles
    sb_push("main_w1", 9);
    sb_push("rank_w1", 32'b00100);
    repeat (9) main_vehicle();
    tick(999 - since);
    check("main_pre_w1", 32'(bus.MAIN_TRAFFIC), 0);
    tick(1);
    sb_check(32'(bus.MAIN_TRAFFIC));
    sb_check(32'(bus.LIGHT_RANK));

    // Window 2: 40 vehicles, the last one on the terminal cycle
    sb_push("main_w2", 40);
    sb_push("rank_w2", 32'b10000);
    repeat (39) main_vehicle();
    tick(1994 - since);
    bus.MAIN_DET = 1'b1;
    tick(5);
    check("main_hold_w1", 32'(bus.MAIN_TRAFFIC), 9);
    tick(1);
    sb_check(32'(bus.MAIN_TRAFFIC));
    sb_check(32'(bus.LIGHT_RANK));
    bus.MAIN_DET = 1'b0;

    // Window 3: the terminal-cycle vehicle must not carry over
    sb_push("main_w3", 0);
    sb_push("rank_w3", 32'b00001);
    tick(3000 - since);
    sb_check(32'(bus.MAIN_TRAFFIC));
    sb_check(32'(bus.LIGHT_RANK));

    // Window 4: main loop held high for 60 cycles
    bus.MAIN_DET = 1'b1;
    tick(60);
`ifdef TRAFFIC_SENSOR_STUCK_DETECT_EN
    check("fault_set", 32'(bus.SENSOR_FAULT), 1);
    bus.MAIN_DET = 1'b0;
    tick(10);
    check("fault_sticky", 32'(bus.SENSOR_FAULT), 1);
    sb_push("main_w4", 7);
    sb_push("rank_w4", 32'b00010);
`else
    check("fault_off", 32'(bus.SENSOR_FAULT), 0);
    bus.MAIN_DET = 1'b0;
    tick(10);
    check("fault_off_later", 32'(bus.SENSOR_FAULT), 0);
    sb_push("main_w4", 1);
    sb_push("rank_w4", 32'b00001);
`endif
    tick(4000 - since);
    sb_check(32'(bus.MAIN_TRAFFIC));
    sb_check(32'(bus.LIGHT_RANK));
    check("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
